// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: 32-step shift-add multiply and restoring divide.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU complete at once with no effect.
module muldiv_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_by_zero
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] FINISH = 2'd2;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   logic [1:0]  state;
   logic [5:0]  cnt;
   logic [63:0] acc;       // {partial hi, partial lo} or {remainder, quotient}
   logic [31:0] opb;       // multiplicand / divisor magnitude
   logic        neg_q;     // negate product, or quotient
   logic        skip;      // FINISH entered without running (no HI/LO write)
`ifdef MULDIV_DIV_EN
   logic        is_div;
   logic        neg_r;
`endif

   logic        accept;
   logic        sgn;
   logic [31:0] mag_a, mag_b;
   logic [32:0] sum;
   logic [63:0] step;
   logic [63:0] res;

   // The done cycle is deliberately a dead cycle for new requests.
   assign accept = start && (state == IDLE) && !done;
   assign sgn    = ~op[0];
   assign mag_a  = (sgn && a[31]) ? -a : a;
   assign mag_b  = (sgn && b[31]) ? -b : b;
   assign busy   = (state == RUN) || (state == FINISH && !skip);

   always_comb begin
      sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
      step = {sum, acc[31:1]};
`ifdef MULDIV_DIV_EN
      if (is_div) begin
         logic [32:0] trial;
         trial = acc[63:31] - {1'b0, opb};
         // Borrow set means the shifted remainder is below the divisor: restore.
         step  = trial[32] ? {acc[62:0], 1'b0} : {trial[31:0], acc[30:0], 1'b1};
      end
`endif
   end

   always_comb begin
      res = neg_q ? -acc : acc;
`ifdef MULDIV_DIV_EN
      if (is_div) begin
         res[63:32] = neg_r ? -acc[63:32] : acc[63:32];
         res[31:0]  = neg_q ? -acc[31:0]  : acc[31:0];
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= 6'd0;
         acc         <= 64'd0;
         opb         <= 32'd0;
         neg_q       <= 1'b0;
         skip        <= 1'b0;
         hi          <= 32'd0;
         lo          <= 32'd0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
`ifdef MULDIV_DIV_EN
         is_div      <= 1'b0;
         neg_r       <= 1'b0;
`endif
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
                     acc   <= {32'd0, mag_a};
                     opb   <= mag_b;
                     neg_q <= sgn && (a[31] ^ b[31]);
                     skip  <= 1'b0;
                     cnt   <= 6'd0;
                     state <= RUN;
`ifdef MULDIV_DIV_EN
                     is_div <= 1'b0;
                     neg_r  <= 1'b0;
`endif
                  end
                  OP_DIV, OP_DIVU: begin
`ifdef MULDIV_DIV_EN
                     if (b == 32'd0) begin
                        skip  <= 1'b1;
                        state <= FINISH;
                     end else begin
                        acc    <= {32'd0, mag_a};
                        opb    <= mag_b;
                        neg_q  <= sgn && (a[31] ^ b[31]);
                        neg_r  <= sgn && a[31];
                        is_div <= 1'b1;
                        skip   <= 1'b0;
                        cnt    <= 6'd0;
                        state  <= RUN;
                     end
`else
                     skip  <= 1'b1;
                     state <= FINISH;
`endif
                  end
                  OP_MTHI: hi <= a;
                  OP_MTLO: lo <= a;
                  default: ;
               endcase
            end
            RUN: begin
               acc <= step;
               cnt <= cnt + 6'd1;
               if (cnt == 6'd31) state <= FINISH;
            end
            FINISH: begin
               done <= 1'b1;
`ifdef MULDIV_DIV_EN
               div_by_zero <= skip;
`endif
               if (!skip) begin
                  hi <= res[63:32];
                  lo <= res[31:0];
               end
               skip  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops against an arithmetic model.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   int checks = 0;
   int passes = 0;
   logic [31:0] hi_m = 32'd0, lo_m = 32'd0;

   muldiv_unit dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) passes++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Expected results straight from the ISA arithmetic rules.
   task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] eh, output logic [31:0] el, output logic edz,
                        output int lat, output int bcyc);
      longint sx, sy, q, r;
      logic [63:0] p;
      eh = hi_m; el = lo_m; edz = 1'b0; lat = 33; bcyc = 33;
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      case (o)
         3'd0: begin p = sx * sy; eh = p[63:32]; el = p[31:0]; end
         3'd1: begin p = {32'd0, x} * {32'd0, y}; eh = p[63:32]; el = p[31:0]; end
         default: begin
`ifdef MULDIV_DIV_EN
            if (y == 32'd0) begin
               edz = 1'b1; lat = 1; bcyc = 0;
            end else if (o == 3'd2) begin
               q = sx / sy; r = sx % sy;
               el = q[31:0]; eh = r[31:0];
            end else begin
               el = x / y; eh = x % y;
            end
`else
            lat = 1; bcyc = 0;
`endif
         end
      endcase
   endtask

   task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
      logic [31:0] eh, el, h0, l0;
      logic edz;
      int lat, bcyc, cyc, bc;
      logic stable;
      model(o, x, y, eh, el, edz, lat, bcyc);
      @(negedge clk); start = 1'b1; op = o; a = x; b = y;
      @(negedge clk); start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
      h0 = hi; l0 = lo; cyc = 0; bc = 0; stable = 1'b1;
      while (done !== 1'b1 && cyc < 100) begin
         if (busy) bc++;
         if (hi !== h0 || lo !== l0) stable = 1'b0;
         @(negedge clk); cyc++;
      end
      chk({tag, " latency"}, 64'(cyc), 64'(lat));
      chk({tag, " busy_cycles"}, 64'(bc), 64'(bcyc));
      chk({tag, " hilo_stable"}, 64'(stable), 64'd1);
      chk({tag, " hi"}, 64'(hi), 64'(eh));
      chk({tag, " lo"}, 64'(lo), 64'(el));
      chk({tag, " dz"}, 64'(div_by_zero), 64'(edz));
      chk({tag, " busy_end"}, 64'(busy), 64'd0);
      hi_m = eh; lo_m = el;
   endtask

   task automatic mt(input logic [2:0] o, input logic [31:0] x);
      @(negedge clk); start = 1'b1; op = o; a = x;
      @(negedge clk); start = 1'b0;
      if (o == 3'b100) hi_m = x; else lo_m = x;
      chk("mt busy", 64'(busy), 64'd0);
      chk("mt done", 64'(done), 64'd0);
      chk("mt hi", 64'(hi), 64'(hi_m));
      chk("mt lo", 64'(lo), 64'(lo_m));
   endtask

   initial begin
      logic [31:0] eh, el, x, y;
      logic edz;
      int lat, bcyc, ndone;
      logic [2:0] o;

      rst_n = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
      #1;
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst done", 64'(done), 64'd0);
      chk("rst dz", 64'(div_by_zero), 64'd0);
      chk("rst hi", 64'(hi), 64'd0);
      chk("rst lo", 64'(lo), 64'd0);
      #12 rst_n = 1'b1;

      run(3'd0, 32'hFFFFFFFD, 32'h00000007, "mult_neg");
      run(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");

      // Request presented in the done cycle must wait one edge.
      start = 1'b1; op = 3'b100; a = 32'hDEAD0001;
      @(negedge clk);
      chk("done_cycle ignored hi", 64'(hi), 64'(hi_m));
      chk("done_cycle done low", 64'(done), 64'd0);
      @(negedge clk); start = 1'b0;
      chk("after_done accepted hi", 64'(hi), 64'hDEAD0001);
      hi_m = 32'hDEAD0001;

      mt(3'b100, 32'h11);
      mt(3'b101, 32'h22);
      run(3'd3, 32'd100, 32'd0, "divu_by0");
      run(3'd2, 32'hFFFFFFF9, 32'd2, "div_neg");
      run(3'd3, 32'd100, 32'd7, "divu");
      run(3'd2, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
      run(3'd2, 32'd5, 32'd0, "div_by0");

      // Reserved op must leave everything untouched.
      @(negedge clk); start = 1'b1; op = 3'b110; a = 32'hCAFEF00D; b = 32'd3;
      @(negedge clk); start = 1'b0;
      ndone = 0;
      repeat (3) begin
         if (busy || done) ndone++;
         @(negedge clk);
      end
      chk("reserved activity", 64'(ndone), 64'd0);
      chk("reserved hi", 64'(hi), 64'(hi_m));
      chk("reserved lo", 64'(lo), 64'(lo_m));

      // MTHI and operand changes while busy are ignored.
      model(3'd1, 32'h12345678, 32'h9ABCDEF0, eh, el, edz, lat, bcyc);
      @(negedge clk); start = 1'b1; op = 3'd1; a = 32'h12345678; b = 32'h9ABCDEF0;
      @(negedge clk); op = 3'b100; a = 32'h5A5A5A5A; b = 32'h1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (done !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
      chk("busy_mthi done seen", 64'(done), 64'd1);
      chk("busy_mthi hi", 64'(hi), 64'(eh));
      chk("busy_mthi lo", 64'(lo), 64'(el));
      hi_m = eh; lo_m = el;

      for (int i = 0; i < 12; i++) begin
         o = 3'($urandom_range(0, 3));
         x = $urandom;
         y = ($urandom_range(0, 3) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 300)));
         if ($urandom_range(0, 2) == 0) x = 32'($urandom_range(0, 5000));
         run(o, x, y, $sformatf("rand%0d op%0d", i, o));
      end

      // Asynchronous reset at E10 of a multiply aborts it.
      @(negedge clk); start = 1'b1; op = 3'd0; a = 32'h7; b = 32'h9;
      @(negedge clk); start = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset busy", 64'(busy), 64'd0);
      chk("midreset hi", 64'(hi), 64'd0);
      chk("midreset lo", 64'(lo), 64'd0);
      chk("midreset done", 64'(done), 64'd0);
      #1 rst_n = 1'b1;
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) ndone++;
      end
      chk("midreset no done", 64'(ndone), 64'd0);
      chk("midreset hi held", 64'(hi), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset. clk is the clock and rst_n is the reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 start  in  1  request strobe, sampled on the rising edge of clk.
REQ-005 op  in  3  operation select: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are reserved.
REQ-006 a  in  32  operand rs (multiplicand / dividend / MTHI/MTLO source).
REQ-007 b  in  32  operand rt (multiplier / divisor).
REQ-008 busy  out  1  high while an iterative operation is in progress.
REQ-009 done  out  1  one-cycle pulse on completion of MULT, MULTU, DIV or DIVU.
REQ-010 hi  out  32  HI register (MFHI source).
REQ-011 lo  out  32  LO register (MFLO source).
REQ-012 div_by_zero  out  1  one-cycle pulse, coincident with done, when a divide has b=0.

Function
REQ-013 FSM states SHALL be IDLE, RUN and FINISH, with a 6-bit step counter.
REQ-014 In IDLE, start=1 with op MULT/MULTU/DIV/DIVU SHALL latch a and b (edge E0) and enter RUN, so busy=1 after E0.
REQ-015 RUN SHALL perform exactly one step per cycle for 32 cycles (E1..E32), then enter FINISH.
  - Multiply: shift-add on operand magnitudes.
  - Divide: restoring division on operand magnitudes.
REQ-016 FINISH (edge E33) SHALL apply the sign correction, write HI/LO, pulse done, deassert busy, and return to IDLE. New hi/lo values and done become visible together after E33.
REQ-017 Multiply results SHALL be {hi,lo} = full 64-bit product, signed for MULT and unsigned for MULTU.
REQ-018 Divide results SHALL be lo=quotient and hi=remainder.
  - DIV truncates toward zero; the remainder takes the sign of the dividend.
  - DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-019 A divide with b=0 SHALL skip RUN. done=1 and div_by_zero=1 SHALL pulse after E1, with hi/lo unchanged and busy=0 after E1.
REQ-020 MTHI/MTLO with start=1 in IDLE SHALL write a into hi/lo at E0, with no busy and no done.
REQ-021 Reserved op codes with start=1 SHALL be ignored; no state changes.
REQ-022 start while busy=1 SHALL be ignored, whatever the op, including MTHI/MTLO. The latched operands are not disturbed.
REQ-023 hi and lo SHALL hold their values between writes, and SHALL not change during RUN.
REQ-024 In the cycle done=1, start=1 is not accepted. The next request is accepted on the following edge, because the FSM is then in IDLE.

Reset
REQ-025 rst_n=0 SHALL immediately force the following, independent of clk:
  - state IDLE, counter 0;
  - hi=0, lo=0;
  - busy=0, done=0, div_by_zero=0.
REQ-026 Reset during RUN SHALL abort the operation with no HI/LO write and no done pulse.

Configuration
REQ-027 The macro MULDIV_DIV_EN SHALL control divider support.
  - Defined: the divide datapath is compiled in and DIV/DIVU behave as in REQ-014..REQ-019.
  - Undefined: no divide logic is built. DIV/DIVU requests pulse done after E1 with busy never set, hi/lo unchanged and div_by_zero=0.

Verification
REQ-028 MULT, a=0xFFFFFFFD, b=0x00000007 -> done after E33; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-029 MULTU, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
REQ-030 DIV, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU, a=100, b=7 -> lo=14, hi=2.
REQ-031 DIVU, a=100, b=0, with hi/lo preloaded via MTHI 0x11 and MTLO 0x22 -> done=div_by_zero=1 after E1; hi=0x11, lo=0x22.
REQ-032 MTHI a=0x5A5A5A5A issued mid-MULT -> ignored (hi keeps its MULT result). rst_n pulsed at E10 of a MULT -> busy=0, hi=lo=0, no done.
REQ-033 With MULTU started and MULDIV_DIV_EN undefined: DIV request -> done after E1, busy stays 0, hi/lo unchanged.
